// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : state, opcode and control-word definitions (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       irwrite;
    logic       memen;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_outdec.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_outdec : state-to-control-word decoder (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter bit FETCH_ONLY_PCINC = 1'b1
) (
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memen   = 1'b1;
        ctrl.alusrcb = FETCH_ONLY_PCINC ? ALUSRCB_FOUR : ALUSRCB_B;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ctrl.alusrcb    = ALUSRCB_IMMSH;
        ctrl.illegal_op = !is_supported(opcode);
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      MEMRD: begin
        ctrl.memen = 1'b1;
        ctrl.iord  = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.memen      = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.alu_op  = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = ALUSRCB_B;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.alu_op  = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl : Moore control FSM for the multi-cycle MIPS datapath (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit FETCH_ONLY_PCINC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memen,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state;
  state_t next_state;
  ctrl_t  dec;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
      MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  multicycle_ctrl_outdec #(
    .FETCH_ONLY_PCINC(FETCH_ONLY_PCINC)
  ) u_outdec (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Reset silences every strobe in the same cycle, even mid-access
  assign ctrl = rst ? '0 : dec;

  assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite;
  assign memen      = ctrl.memen;
  assign memwrite   = ctrl.memwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign alu_op     = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : randomized self-checking bench for multicycle_ctrl (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcen, iord, irwrite, memen, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, alu_op;
  logic       instr_done, illegal_op;
  logic [16:0] outw;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic        rdy_q[$];
  int          fetch_len;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memen(memen), .memwrite(memwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign outw = {pcen, iord, irwrite, memen, memwrite, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, pcsrc, alu_op, instr_done, illegal_op};

  function automatic logic [16:0] mk(input logic pe, io, irw, men, mw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, ps, aop, input logic dn, il);
    return {pe, io, irw, men, mw, rd, m2r, rw, asa, asb, ps, aop, dn, il};
  endfunction

  // Cycles per instruction with all stalls added; -1 means no completion pulse
  function automatic int latency(input logic [5:0] op, input int fst, input int mst);
    case (op)
      OP_LW:            return 5 + fst + mst;
      OP_SW:            return 4 + fst + mst;
      OP_RTYPE, OP_ADDI: return 4 + fst;
      OP_BEQ, OP_J:     return 3 + fst;
      default:          return -1;
    endcase
  endfunction

  task automatic push(input logic [16:0] w, input logic r);
    exp_q.push_back(w);
    rdy_q.push_back(r);
  endtask

  // Expected per-cycle control words for one instruction, from the instruction's step list
  task automatic plan(input logic [5:0] op, input logic zv, input int fst, input int mst);
    logic legal;
    exp_q.delete();
    rdy_q.delete();
    fetch_len = fst + 1;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    for (int i = 0; i < fst; i++) push(mk(0,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b0);
    push(mk(1,0,1,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), 1'b1);
    push(mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,!legal), 1'($urandom_range(0,1)));
    case (op)
      OP_LW: begin
        push(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'($urandom_range(0,1)));
        for (int i = 0; i < mst; i++) push(mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0);
        push(mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b1);
        push(mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0), 1'($urandom_range(0,1)));
      end
      OP_SW: begin
        push(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'($urandom_range(0,1)));
        for (int i = 0; i < mst; i++) push(mk(0,1,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,0,0), 1'b0);
        push(mk(0,1,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,1,0), 1'b1);
      end
      OP_RTYPE: begin
        push(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0,0), 1'($urandom_range(0,1)));
        push(mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0), 1'($urandom_range(0,1)));
      end
      OP_BEQ:
        push(mk(zv,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0), 1'($urandom_range(0,1)));
      OP_ADDI: begin
        push(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), 1'($urandom_range(0,1)));
        push(mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0), 1'($urandom_range(0,1)));
      end
      OP_J:
        push(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,1,0), 1'($urandom_range(0,1)));
      default: ;
    endcase
  endtask

  // Drives n cycles of the planned instruction and records the observed words
  task automatic exec(input logic [5:0] op, input logic zv, input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst       = 1'b0;
      mem_ready = rdy_q[i];
      zero      = zv;
      opcode    = (i < fetch_len) ? 6'($urandom) : op;
      #1;
      obs_q.push_back(outw);
    end
  endtask

  function automatic int first_done();
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][1]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'($urandom);
      #1;
      checks++;
      if (outw !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got %h want %h", c, outw, 17'd0);
      end
    end
  endtask

  task automatic test_lw();
    plan(OP_LW, 1'($urandom_range(0,1)), 0, 0);
    exec(OP_LW, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (first_done() !== latency(OP_LW, 0, 0) - 1) begin
      errors++;
      $display("FAIL lw_latency: got %0d want %0d", first_done(), latency(OP_LW, 0, 0) - 1);
    end
  endtask

  task automatic test_sw_stall();
    plan(OP_SW, 1'b0, 0, 2);
    exec(OP_SW, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sw_stall cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (first_done() !== latency(OP_SW, 0, 2) - 1) begin
      errors++;
      $display("FAIL sw_latency: got %0d want %0d", first_done(), latency(OP_SW, 0, 2) - 1);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      plan(OP_BEQ, 1'(z), 0, 0);
      exec(OP_BEQ, 1'(z), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL beq_z%0d cyc%0d: got %h want %h", z, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rtype_j();
    logic [5:0] ops[2];
    int total;
    ops[0] = OP_RTYPE;
    ops[1] = OP_J;
    total = 0;
    for (int k = 0; k < 2; k++) begin
      plan(ops[k], 1'b0, 0, 0);
      exec(ops[k], 1'b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rtype_j op%0d cyc%0d: got %h want %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      total += first_done() + 1;
    end
    checks++;
    if (total !== 7) begin
      errors++;
      $display("FAIL rtype_j_total: got %0d want %0d", total, 7);
    end
  endtask

  task automatic test_illegal();
    plan(6'b111111, 1'b1, 0, 0);
    exec(6'b111111, 1'b1, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_memrd();
    plan(OP_LW, 1'b0, 0, 3);
    exec(OP_LW, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL memrd_prefix cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (outw !== 17'd0) begin
      errors++;
      $display("FAIL memrd_reset_cycle: got %h want %h", outw, 17'd0);
    end
    plan(OP_ADDI, 1'b0, 1, 0);
    exec(OP_ADDI, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL after_reset cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[6];
    logic [5:0] op;
    logic       zv;
    int         fst, mst;
    pool[0] = OP_LW;  pool[1] = OP_SW;   pool[2] = OP_RTYPE;
    pool[3] = OP_BEQ; pool[4] = OP_ADDI; pool[5] = OP_J;
    for (int n = 0; n < 60; n++) begin
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 5)];
      zv  = 1'($urandom_range(0, 1));
      fst = $urandom_range(0, 3);
      mst = $urandom_range(0, 3);
      plan(op, zv, fst, mst);
      exec(op, zv, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random n%0d op%b cyc%0d: got %h want %h", n, op, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (first_done() !== latency(op, fst, mst) - ((latency(op, fst, mst) < 0) ? 0 : 1)) begin
        errors++;
        $display("FAIL random_latency n%0d op%b: got %0d want %0d", n, op, first_done(),
                 latency(op, fst, mst) - ((latency(op, fst, mst) < 0) ? 0 : 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_rtype_j();
    test_illegal();
    test_reset_mid_memrd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS datapath for the lw, sw, R-type, beq, addi and j subset.
- Replaces the single-cycle opcode decoder wherever the datapath has one memory port, one ALU, and IR/A/B/ALUOut holding registers.
- Drives every datapath strobe and mux select once per cycle.
- Stalls on a memory-ready handshake.

Parameters:
- FETCH_ONLY_PCINC, 1, when 1 the FETCH state computes PC+4 on the ALU (alusrcb=01); when 0, alusrcb=00 (test hook only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC write enable = pcwrite | (branch & zero)
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- irwrite  out  1  load IR
- memen  out  1  memory access request
- memwrite  out  1  write strobe, qualified by memen
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = write-back from the memory data register
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- State register is 4 bits. Outputs are decoded from state only, except pcen, which also uses zero, and the mem_ready-qualified strobes noted below.
- Reset: on a clk edge with rst=1, state <= FETCH. While rst=1, outputs are forced to: pcen, irwrite, memen, memwrite, regwrite, instr_done and illegal_op = 0; all selects = 0.
- Reset taken in any state, including mid-memory access, aborts the instruction. No write strobe may assert in the reset cycle.
- State outputs and transitions (signals not listed are 0):
  - FETCH: memen=1, iord=0, alusrca=0, alusrcb=01, alu_op=00, pcsrc=00. irwrite and pcwrite assert only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alusrca=0, alusrcb=11, alu_op=00 (precomputes the branch target). Next state by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other opcode -> FETCH, with illegal_op=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, alu_op=00. Next is MEMRD if opcode=100011, else MEMWR.
  - MEMRD: memen=1, iord=1. Wait while mem_ready=0, then go to MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next is FETCH.
  - MEMWR: memen=1, memwrite=1, iord=1. Hold all three stable while mem_ready=0. On mem_ready=1: instr_done=1, next is FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, alu_op=10. Next is RTYPEWB.
  - RTYPEWB: regdst=1, regwrite=1, instr_done=1. Next is FETCH.
  - BEQEX: alusrca=1, alusrcb=00, alu_op=01, pcsrc=01, branch=1, so pcen=zero. instr_done=1. Next is FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, alu_op=00. Next is ADDIWB.
  - ADDIWB: regdst=0, regwrite=1, instr_done=1. Next is FETCH.
  - JEX: pcsrc=10, pcwrite=1, instr_done=1. Next is FETCH.
- Latency with mem_ready tied high, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Unreachable state encodings go to FETCH on the next edge, with all outputs 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state encoding constants (FETCH=0 through JEX=11)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOP_ADD/SUB/FUNCT, ALUSRCB_* and PCSRC_* constants
- One sub-module, multicycle_ctrl_outdec: purely combinational state-to-control-word decoder. The top level keeps the state register, the next-state logic and the pcen gating.

Test Plan:
- rst high for 2 cycles, then lw with mem_ready=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 with memtoreg=1 and regdst=0 in cycle 5. instr_done pulses once.
- sw with mem_ready low for 2 cycles in MEMWR -> memwrite=1, memen=1, iord=1 held for 3 cycles. Return to FETCH after mem_ready rises. regwrite never asserts.
- beq with zero=1, then again with zero=0 -> in BEQEX, pcen=1 with pcsrc=01 in the first case; pcen=0 in the second. Both take 3 cycles.
- R-type followed by j -> RTYPEWB shows regdst=1, alu_op was 10 in RTYPEEX. JEX shows pcsrc=10, pcen=1. Total 7 cycles.
- opcode 6'b111111 in DECODE -> illegal_op pulses for 1 cycle, next state FETCH, no regwrite or memwrite asserted.
- rst asserted during MEMRD while mem_ready=0 -> next cycle is FETCH, memen=0 during the reset cycle, no instr_done pulse.
